// File: rtl/jts16b_snd_pkg.sv
// jts16b_snd_pkg: shared state encoding and default depth for the sound latch
package jts16b_snd_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, WAIT = 2'd2} snd_state_e;
  localparam int SND_DEPTH = 4;
endpackage

// File: rtl/jts16b_sndlatch_if.sv
// jts16b_sndlatch_if: 68000/Z80 command and reply bus of the sound latch
interface jts16b_sndlatch_if;
  logic       cmd_we;
  logic [7:0] cmd_din;
  logic       cmd_full;
  logic [4:0] cmd_level;
  logic [7:0] ovf_cnt;
  logic       z80_rd;
  logic       z80_iack;
  logic [7:0] z80_dout;
  logic       z80_intn;
  logic       rep_we;
  logic [7:0] rep_din;
  logic       rep_rd;
  logic [7:0] rep_dout;
  logic       rep_full;
  modport master (
    output cmd_we, cmd_din, z80_rd, z80_iack, rep_we, rep_din, rep_rd,
    input  cmd_full, cmd_level, ovf_cnt, z80_dout, z80_intn, rep_dout, rep_full
  );
  modport slave (
    input  cmd_we, cmd_din, z80_rd, z80_iack, rep_we, rep_din, rep_rd,
    output cmd_full, cmd_level, ovf_cnt, z80_dout, z80_intn, rep_dout, rep_full
  );
endinterface

// File: rtl/jts16b_sndfifo.sv
// jts16b_sndfifo: command FIFO with registered head output and saturating drop counter
module jts16b_sndfifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] din,
  input  logic       rd,
  output logic       full,
  output logic [4:0] level,
  output logic [4:0] level_nxt,
  output logic [7:0] ovf_cnt,
  output logic [7:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [4:0]    level_q, level_d;
  logic [7:0]    ovf_q, ovf_d, dout_q, dout_d;
  logic          push, pop;
  // push/pop decisions; a read on an empty FIFO with a coincident write passes the byte straight through
  always_comb begin
    full      = level_q == 5'(DEPTH);
    push      = we && (!full || rd);
    pop       = rd && (level_q != 5'd0 || push);
    wr_d      = wr_q + AW'(push);
    rd_d      = rd_q + AW'(pop);
    level_d   = level_q + 5'(push) - 5'(pop);
    ovf_d     = ovf_q + 8'(we && !push && ovf_q != 8'hff);
    dout_d    = (push && (level_q == 5'(pop) || level_q == 5'd0)) ? din :
                (level_d != 5'd0) ? mem_q[rd_d] : dout_q;
    level     = level_q;
    level_nxt = level_d;
    ovf_cnt   = ovf_q;
    dout      = dout_q;
  end
  // pointer, level, counter and head registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= '0;
      dout_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
    end
  end
  // storage, left unreset
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/jts16b_sndlatch.sv
// jts16b_sndlatch: 68000-to-Z80 sound command FIFO with interrupt FSM and reply latch
module jts16b_sndlatch
  import jts16b_snd_pkg::*;
#(
  parameter int DEPTH = SND_DEPTH
) (
  input logic               clk,
  input logic               rst,
  jts16b_sndlatch_if.slave  bus
);
  logic [4:0] level, level_nxt;
  snd_state_e st_q;
  logic       intn_q;
  logic [7:0] rep_dout_q, rep_dout_d;
  logic       rep_full_q, rep_full_d;
  jts16b_sndfifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .we        (bus.cmd_we),
    .din       (bus.cmd_din),
    .rd        (bus.z80_rd),
    .full      (bus.cmd_full),
    .level     (level),
    .level_nxt (level_nxt),
    .ovf_cnt   (bus.ovf_cnt),
    .dout      (bus.z80_dout)
  );
  // interrupt request: raised while commands wait, held off between acknowledge and the next read
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      intn_q <= 1'b1;
    end else begin
      case (st_q)
        IDLE: if (level != 5'd0) begin
          st_q   <= PEND;
          intn_q <= 1'b0;
        end
        PEND: if (bus.z80_rd && level_nxt == 5'd0) begin
          st_q   <= IDLE;
          intn_q <= 1'b1;
        end else if (bus.z80_iack) begin
          st_q   <= WAIT;
          intn_q <= 1'b1;
        end
        WAIT: if (bus.z80_rd) begin
          st_q   <= level_nxt == 5'd0 ? IDLE : PEND;
          intn_q <= level_nxt == 5'd0;
        end
        default: begin
          st_q   <= IDLE;
          intn_q <= 1'b1;
        end
      endcase
    end
  end
  // reply latch next state; a write beats a coincident read
  always_comb begin
    rep_full_d    = bus.rep_we || (rep_full_q && !bus.rep_rd);
    rep_dout_d    = bus.rep_we ? bus.rep_din : rep_dout_q;
    bus.cmd_level = level;
    bus.z80_intn  = intn_q;
    bus.rep_dout  = rep_dout_q;
    bus.rep_full  = rep_full_q;
  end
  // reply latch registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_full_q <= 1'b0;
      rep_dout_q <= '0;
    end else begin
      rep_full_q <= rep_full_d;
      rep_dout_q <= rep_dout_d;
    end
  end
endmodule

// File: tb/tb_jts16b_sndlatch.sv
// tb_jts16b_sndlatch: directed and random checks of the sound latch against a queue model
module tb_jts16b_sndlatch;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  jts16b_sndlatch_if bus();
  jts16b_sndlatch #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  logic [7:0] mq[$];
  logic [7:0] m_last;
  int         m_ovf;
  int         m_st;
  logic [7:0] m_rep;
  logic       m_repf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = 8'h00;
    m_ovf  = 0;
    m_st   = 0;
    m_rep  = 8'h00;
    m_repf = 1'b0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".level"}, 32'(bus.cmd_level), mq.size());
    chk({tag, ".full"},  32'(bus.cmd_full), mq.size() == DEPTH);
    chk({tag, ".ovf"},   32'(bus.ovf_cnt), m_ovf);
    chk({tag, ".dout"},  32'(bus.z80_dout), mq.size() > 0 ? mq[0] : m_last);
    chk({tag, ".intn"},  32'(bus.z80_intn), m_st != 1);
    chk({tag, ".rdout"}, 32'(bus.rep_dout), m_rep);
    chk({tag, ".rfull"}, 32'(bus.rep_full), m_repf);
  endtask

  task automatic step(input string tag, input logic we, input logic [7:0] d, input logic rd,
                      input logic iack, input logic rwe, input logic [7:0] rdin, input logic rrd);
    int  old_n;
    bit  push, rd_left;
    bus.cmd_we = we; bus.cmd_din = d; bus.z80_rd = rd; bus.z80_iack = iack;
    bus.rep_we = rwe; bus.rep_din = rdin; bus.rep_rd = rrd;
    @(posedge clk);
    old_n   = mq.size();
    push    = we && (old_n < DEPTH || rd);
    rd_left = rd;
    if (we && !push && m_ovf < 255) m_ovf++;
    if (rd && old_n > 0) begin m_last = mq.pop_front(); rd_left = 0; end
    if (push) mq.push_back(d);
    if (rd_left && mq.size() > 0) m_last = mq.pop_front();
    if (m_st == 0) m_st = old_n > 0 ? 1 : 0;
    else if (m_st == 1) m_st = (rd && mq.size() == 0) ? 0 : iack ? 2 : 1;
    else if (rd) m_st = mq.size() == 0 ? 0 : 1;
    if (rwe) begin m_rep = rdin; m_repf = 1'b1; end
    else if (rrd) m_repf = 1'b0;
    #1;
    chk_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 8'h00, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic do_reset(input string tag);
    bus.cmd_we = 1'b1; bus.cmd_din = 8'($urandom); bus.z80_rd = 1'b1; bus.z80_iack = 1'b1;
    bus.rep_we = 1'b1; bus.rep_din = 8'($urandom); bus.rep_rd = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk_all(tag);
  endtask

  initial begin
    model_reset();
    do_reset("rst0");
    chk("rst0.intn_c", 32'(bus.z80_intn), 1);
    step("p5a", 1, 8'h5A, 0, 0, 0, 8'h00, 0);
    chk("p5a.dout_c", 32'(bus.z80_dout), 8'h5A);
    chk("p5a.intn_hi", 32'(bus.z80_intn), 1);
    idle("p5a+2");
    chk("p5a.intn_lo", 32'(bus.z80_intn), 0);
    step("iack", 0, 8'h00, 0, 1, 0, 8'h00, 0);
    step("rd5a", 0, 8'h00, 1, 0, 0, 8'h00, 0);
    chk("rd5a.intn_c", 32'(bus.z80_intn), 1);
    chk("rd5a.level_c", 32'(bus.cmd_level), 0);
    step("rd_empty", 0, 8'h00, 1, 0, 0, 8'h00, 0);
    chk("rd_empty.dout_c", 32'(bus.z80_dout), 8'h5A);

    do_reset("rst1");
    for (int i = 1; i <= 5; i++) step("fill", 1, 8'(i), 0, 0, 0, 8'h00, 0);
    chk("fill.full_c", 32'(bus.cmd_full), 1);
    chk("fill.ovf_c", 32'(bus.ovf_cnt), 1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain.head", 32'(bus.z80_dout), i);
      step("drain", 0, 8'h00, 1, 0, 0, 8'h00, 0);
    end
    for (int i = 0; i < 4; i++) step("refill", 1, 8'(8'h10 + i), 0, 0, 0, 8'h00, 0);
    step("pushpop", 1, 8'h77, 1, 0, 0, 8'h00, 0);
    chk("pushpop.level_c", 32'(bus.cmd_level), 4);
    chk("pushpop.ovf_c", 32'(bus.ovf_cnt), 1);
    for (int i = 0; i < 3; i++) step("drain2", 0, 8'h00, 1, 0, 0, 8'h00, 0);
    chk("drain2.last", 32'(bus.z80_dout), 8'h77);
    step("drain2", 0, 8'h00, 1, 0, 0, 8'h00, 0);
    step("pass0", 1, 8'h3C, 1, 0, 0, 8'h00, 0);
    chk("pass0.level_c", 32'(bus.cmd_level), 0);

    do_reset("rst2");
    step("q2a", 1, 8'hA1, 0, 0, 0, 8'h00, 0);
    step("q2b", 1, 8'hB2, 0, 0, 0, 8'h00, 0);
    idle("q2idle");
    step("q2iack", 0, 8'h00, 0, 1, 0, 8'h00, 0);
    step("q2wpush", 1, 8'hC4, 0, 0, 0, 8'h00, 0);
    chk("q2wpush.intn_c", 32'(bus.z80_intn), 1);
    step("q2rd1", 0, 8'h00, 1, 0, 0, 8'h00, 0);
    chk("q2rd1.intn_c", 32'(bus.z80_intn), 0);
    step("q2rd2", 0, 8'h00, 1, 0, 0, 8'h00, 0);
    step("q2rd3", 0, 8'h00, 1, 0, 0, 8'h00, 0);
    chk("q2rd3.intn_c", 32'(bus.z80_intn), 1);
    step("iack_idle", 0, 8'h00, 0, 1, 0, 8'h00, 0);

    step("rep_nop", 0, 8'h00, 0, 0, 0, 8'h00, 1);
    step("rep_wr", 0, 8'h00, 0, 0, 1, 8'hC3, 1);
    chk("rep_wr.full_c", 32'(bus.rep_full), 1);
    chk("rep_wr.dout_c", 32'(bus.rep_dout), 8'hC3);
    idle("rep_hold");
    step("rep_rd", 0, 8'h00, 0, 0, 0, 8'h00, 1);
    chk("rep_rd.full_c", 32'(bus.rep_full), 0);

    do_reset("rst3");
    for (int i = 0; i < 300; i++) step("ovf", 1, 8'($urandom), 0, 0, 0, 8'h00, 0);
    chk("ovf.sat", 32'(bus.ovf_cnt), 255);
    do_reset("rst4");
    chk("rst4.ovf_c", 32'(bus.ovf_cnt), 0);
    chk("rst4.level_c", 32'(bus.cmd_level), 0);

    for (int b = 0; b < 6; b++) begin
      int pw = 20 + 15 * b;
      int pr = 90 - 15 * b;
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(199) == 0) do_reset("rnd_rst");
        else step("rnd", $urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < pr,
                  $urandom_range(3) == 0, $urandom_range(5) == 0, 8'($urandom),
                  $urandom_range(4) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
